cyq_seg7_scan: RTL and testbench
================================

# cyq_seg7_scan

Multiplexed 4-digit 7-segment display driver downstream of the cascaded cyq_74HC161 counter stages. It snapshots the 16-bit count formed by four counter nibbles and decodes one digit at a time to hex segments, scanning the digits at a rate set by a prescaler. It also latches a sticky overflow flag from the terminal-count output of the most significant stage.

## Interface
- SCAN_DIV, default 1000: clk cycles per digit slot; legal range ≥ 1.
- clk  in  1  rising-edge system clock; shared with the counter stages.
- MR  in  1  reset; asynchronous, active-high.
- Din  in  16  cascaded counter outputs; Din[3:0] is the least significant stage Q, Din[15:12] is the most significant stage Q.
- TC  in  1  terminal count of the most significant counter stage.
- Cen  in  1  count enable seen by that stage (Cep & Cet); overflow event = TC & Cen.
- Hold  in  1  1 = freeze the snapshot; 0 = track Din.
- Clr_ovf  in  1  synchronous clear of the overflow flag.
- Seg  out  7  segments, active-high; Seg[0]=a … Seg[6]=g.
- Dp  out  1  decimal point, active-high.
- An  out  4  digit enables, active-low, one-hot-low; An[0] = least significant digit.
- Ovf  out  1  sticky overflow flag.

## Operation
- Snapshot register snap[15:0]: on each clk edge, snap <= Din when Hold=0 and holds its value when Hold=1.
- Prescaler pc counts 0..SCAN_DIV-1 and wraps. tick = (pc == SCAN_DIV-1). Width is $clog2(SCAN_DIV) bits, minimum 1. With SCAN_DIV=1, tick is high every cycle.
- Scan index idx[1:0] advances on each tick: 0→1→2→3→0.
- On the tick edge, the following update together:
  - An <= ~(4'b0001 << next_idx).
  - Seg <= decode(snap nibble at next_idx).
  - Dp <= (next_idx==3) & Ovf.
- Between ticks, Seg, An and Dp hold their values.
- Hex decode, values in gfedcba order:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Overflow flag:
  - Ovf <= 1 on an edge where TC & Cen = 1.
  - Ovf <= 0 on an edge where Clr_ovf=1 and no overflow event occurs.
  - If the event and Clr_ovf coincide, set wins.
  - Hold does not affect Ovf.

## Timing
- Reset values: pc=0, idx=3, snap=0, Seg=7'h00, Dp=0, An=4'b1111, Ovf=0.
- The first tick occurs SCAN_DIV cycles after MR deasserts and selects digit 0 (An=4'b1110).
- Latency from Din to snap: 1 cycle. A digit shows the snap value sampled at its own tick edge.
- Each digit is driven for exactly SCAN_DIV cycles. Full frame = 4·SCAN_DIV cycles.
- Ovf rises one cycle after the qualifying edge. The Dp reflection waits until the next digit-3 slot.
- MR asserted mid-scan: every register returns to its reset value immediately, with no clock required.
- Hold toggling mid-frame is legal. The value shown on each digit is whatever snap holds at that digit's tick.

## Configuration
- Macro: CYQ_SEG7_LZB_EN (leading-zero blanking).
- Defined:
  - Digit k (k=3,2,1) shows Seg=7'h00 when snap nibbles k..3 are all zero.
  - Digit 0 is never blanked; a value of 0 shows a single "0".
  - An still scans all four digits.
  - Dp on digit 3 is unaffected by blanking.
- Undefined: all four digits are always decoded, including leading zeros.

## Structure
- Package cyq_seg7_pkg holds:
  - SEG_BLANK = 7'h00;
  - localparam NDIG = 4;
  - the 16-entry hex segment constants;
  - function seg_decode(input [3:0]) returning [6:0].
- One sub-module, cyq_seg7_dec: purely combinational nibble → segment decoder built from the package function. The top level instantiates it once on the muxed nibble.
- Prescaler, scan index, snapshot and overflow logic stay in cyq_seg7_scan.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset release, Din=16'h1234, Hold=0 → An sequence 1110,1101,1011,0111 every 4 cycles; Seg sequence 66 (4), 4F (3), 5B (2), 06 (1); Dp=0 throughout.
- Din=16'hABCD, then Hold=1, then Din=16'h0000 → display keeps scanning 5E, 39, 7C, 77.
- TC=1, Cen=1 for one cycle → Ovf=1 next cycle; Dp=1 only while An=0111. Clr_ovf pulse → Ovf=0. TC&Cen coincident with Clr_ovf → Ovf stays 1.
- Din=16'h0007 with CYQ_SEG7_LZB_EN defined → digits 3..1 show Seg=00 and digit 0 shows 07. Without the macro → digits show 3F,3F,3F,07. Din=0 with the macro → only digit 0 lit, showing 3F.
- MR pulsed mid-frame while An=1011 → An=1111, Seg=00, Ovf=0 asynchronously; first digit-0 slot follows 4 cycles after release.
- SCAN_DIV=1 build → An changes every cycle; the full 4-digit frame repeats every 4 cycles.

Source files
------------

// File: rtl/cyq_seg7_pkg.sv
// cyq_seg7_pkg: shared constants and hex-to-segment decode for the
// cyq_seg7 display driver (segments in gfedcba order, active-high).
package cyq_seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam int         NDIG      = 4;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/cyq_seg7_dec.sv
// cyq_seg7_dec: combinational nibble to 7-segment decoder.
// Ports: i_nib [3:0] hex digit in; o_seg [6:0] segments out (Seg[0]=a).
module cyq_seg7_dec
    import cyq_seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = seg_decode(i_nib);

endmodule

// File: rtl/cyq_seg7_scan.sv
// cyq_seg7_scan: 4-digit multiplexed 7-segment driver with snapshot,
// prescaled digit scan and sticky overflow flag.
// Ports: clk, MR (async active-high reset), Din[15:0] counter nibbles,
//   TC/Cen overflow event inputs, Hold (freeze snapshot), Clr_ovf,
//   Seg[6:0] active-high segments, Dp, An[3:0] active-low digit enables,
//   Ovf sticky overflow.
// Build option: define CYQ_SEG7_LZB_EN for leading-zero blanking.
module cyq_seg7_scan
    import cyq_seg7_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        MR,
    input  logic [15:0] Din,
    input  logic        TC,
    input  logic        Cen,
    input  logic        Hold,
    input  logic        Clr_ovf,
    output logic [6:0]  Seg,
    output logic        Dp,
    output logic [3:0]  An,
    output logic        Ovf
);

    localparam int PCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PCW-1:0] PC_LAST = PCW'(SCAN_DIV - 1);

    logic [PCW-1:0]  r_pc;
    logic [1:0]      r_idx;
    logic [15:0]     r_snap;
    logic [6:0]      r_seg;
    logic [NDIG-1:0] r_an;
    logic            r_dp;
    logic            r_ovf;

    logic            w_tick;
    logic [1:0]      w_nidx;
    logic [3:0]      w_nib;
    logic [6:0]      w_dec_seg;
    logic            w_blank;
    logic [6:0]      w_seg_nxt;
    logic            w_ovf_ev;

    assign w_tick   = (r_pc == PC_LAST);
    assign w_nidx   = r_idx + 2'd1;
    assign w_ovf_ev = TC & Cen;

    // Nibble of the current snapshot for the digit about to be shown.
    always_comb begin
        w_nib = r_snap[3:0];
        unique case (w_nidx)
            2'd0: w_nib = r_snap[3:0];
            2'd1: w_nib = r_snap[7:4];
            2'd2: w_nib = r_snap[11:8];
            2'd3: w_nib = r_snap[15:12];
        endcase
    end

`ifdef CYQ_SEG7_LZB_EN
    // A digit is blank when it and every more significant nibble are zero;
    // digit 0 always shows so a zero count reads "0".
    always_comb begin
        w_blank = 1'b0;
        unique case (w_nidx)
            2'd0: w_blank = 1'b0;
            2'd1: w_blank = (r_snap[15:4] == 12'h000);
            2'd2: w_blank = (r_snap[15:8] == 8'h00);
            2'd3: w_blank = (r_snap[15:12] == 4'h0);
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    cyq_seg7_dec u_dec (
        .i_nib (w_nib),
        .o_seg (w_dec_seg)
    );

    assign w_seg_nxt = w_blank ? SEG_BLANK : w_dec_seg;

    always_ff @(posedge clk or posedge MR) begin
        if (MR) begin
            r_pc   <= '0;
            r_idx  <= 2'd3;
            r_snap <= '0;
            r_seg  <= SEG_BLANK;
            r_an   <= '1;
            r_dp   <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_pc <= w_tick ? '0 : r_pc + 1'b1;
            if (!Hold) begin
                r_snap <= Din;
            end
            // Set beats clear when both arrive on the same edge.
            if (w_ovf_ev) begin
                r_ovf <= 1'b1;
            end else if (Clr_ovf) begin
                r_ovf <= 1'b0;
            end
            if (w_tick) begin
                r_idx <= w_nidx;
                r_an  <= ~(NDIG'(1) << w_nidx);
                r_seg <= w_seg_nxt;
                r_dp  <= (w_nidx == 2'd3) & r_ovf;
            end
        end
    end

    assign Seg = r_seg;
    assign An  = r_an;
    assign Dp  = r_dp;
    assign Ovf = r_ovf;

endmodule

// File: tb/tb_cyq_seg7_scan.sv
// tb_cyq_seg7_scan: checks two cyq_seg7_scan builds (SCAN_DIV=4 and 1)
// against a cycle-count based reference model plus literal expectations.
module tb_cyq_seg7_scan;

`ifdef CYQ_SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam int DV [2] = '{4, 1};

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        MR = 1'b0;
    logic [15:0] Din = 16'h0;
    logic        TC = 1'b0;
    logic        Cen = 1'b0;
    logic        Hold = 1'b0;
    logic        Clr_ovf = 1'b0;

    logic [6:0] o_seg [2];
    logic       o_dp  [2];
    logic [3:0] o_an  [2];
    logic       o_ovf [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cyq_seg7_scan #(.SCAN_DIV(4)) dut (
        .clk(clk), .MR(MR), .Din(Din), .TC(TC), .Cen(Cen),
        .Hold(Hold), .Clr_ovf(Clr_ovf),
        .Seg(o_seg[0]), .Dp(o_dp[0]), .An(o_an[0]), .Ovf(o_ovf[0])
    );

    cyq_seg7_scan #(.SCAN_DIV(1)) dut1 (
        .clk(clk), .MR(MR), .Din(Din), .TC(TC), .Cen(Cen),
        .Hold(Hold), .Clr_ovf(Clr_ovf),
        .Seg(o_seg[1]), .Dp(o_dp[1]), .An(o_an[1]), .Ovf(o_ovf[1])
    );

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // What a digit slot shows for a given snapshot.
    function automatic logic [6:0] shown(input logic [15:0] s, input int slot);
        logic [15:0] hi;
        hi = s >> (4 * slot);
        if (LZB && slot > 0 && hi == 16'h0) return 7'h00;
        return HEX[hi[3:0]];
    endfunction

    // Reference model: edges since reset release decide when a slot starts.
    int          m_cnt = 0;
    logic [15:0] m_snap = 16'h0;
    logic        m_ovf = 1'b0;
    logic [6:0]  m_seg [2] = '{7'h00, 7'h00};
    logic [3:0]  m_an  [2] = '{4'hF, 4'hF};
    logic        m_dp  [2] = '{1'b0, 1'b0};

    always @(posedge clk or posedge MR) begin
        if (MR) begin
            m_cnt  <= 0;
            m_snap <= 16'h0;
            m_ovf  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_seg[i] <= 7'h00;
                m_an[i]  <= 4'hF;
                m_dp[i]  <= 1'b0;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            for (int i = 0; i < 2; i++) begin
                if ((m_cnt + 1) % DV[i] == 0) begin
                    m_an[i]  <= 4'hF ^ (4'd1 << ((((m_cnt + 1) / DV[i]) - 1) % 4));
                    m_seg[i] <= shown(m_snap, (((m_cnt + 1) / DV[i]) - 1) % 4);
                    m_dp[i]  <= (((((m_cnt + 1) / DV[i]) - 1) % 4) == 3) && m_ovf;
                end
            end
            if (!Hold) m_snap <= Din;
            m_ovf <= (TC && Cen) ? 1'b1 : (Clr_ovf ? 1'b0 : m_ovf);
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("seg[d%0d]", DV[i]), 16'(o_seg[i]), 16'(m_seg[i]));
            chk($sformatf("an[d%0d]", DV[i]), 16'(o_an[i]), 16'(m_an[i]));
            chk($sformatf("dp[d%0d]", DV[i]), 16'(o_dp[i]), 16'(m_dp[i]));
            chk($sformatf("ovf[d%0d]", DV[i]), 16'(o_ovf[i]), 16'(m_ovf));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for the 4-divider build to select a given digit.
    task automatic wait_an(input logic [3:0] an);
        for (int k = 0; k < 20 && o_an[0] !== an; k++) @(negedge clk);
        chk("wait_an", 16'(o_an[0]), 16'(an));
    endtask

    initial begin
        #1 MR = 1'b1;
        cyc(3);
        chk("rst_an", 16'(o_an[0]), 16'hF);
        chk("rst_seg", 16'(o_seg[0]), 16'h00);
        chk("rst_ovf", 16'(o_ovf[0]), 16'h0);

        MR  = 1'b0;
        Din = 16'h1234;
        cyc(1);
        chk("d1_an0", 16'(o_an[1]), 16'hE);
        chk("d1_seg0", 16'(o_seg[1]), 16'h3F);
        cyc(1);
        chk("d1_an1", 16'(o_an[1]), 16'hD);
        chk("d1_seg1", 16'(o_seg[1]), 16'h4F);
        cyc(1);
        chk("pre_tick_an", 16'(o_an[0]), 16'hF);
        cyc(1);
        chk("first_an", 16'(o_an[0]), 16'hE);
        chk("first_seg", 16'(o_seg[0]), 16'h66);
        cyc(4);
        chk("dig1_an", 16'(o_an[0]), 16'hD);
        chk("dig1_seg", 16'(o_seg[0]), 16'h4F);
        cyc(8);
        chk("dig3_seg", 16'(o_seg[0]), 16'h06);
        chk("dig3_dp", 16'(o_dp[0]), 16'h0);

        Din = 16'hABCD;
        cyc(2);
        Hold = 1'b1;
        Din  = 16'h0000;
        cyc(4);
        wait_an(4'b1110);
        chk("hold_d0", 16'(o_seg[0]), 16'h5E);
        wait_an(4'b0111);
        chk("hold_d3", 16'(o_seg[0]), 16'h77);
        Hold = 1'b0;

        TC = 1'b1; Cen = 1'b1;
        cyc(1);
        TC = 1'b0; Cen = 1'b0;
        chk("ovf_set", 16'(o_ovf[0]), 16'h1);
        cyc(4);
        wait_an(4'b0111);
        chk("ovf_dp", 16'(o_dp[0]), 16'h1);
        Clr_ovf = 1'b1;
        cyc(1);
        Clr_ovf = 1'b0;
        chk("ovf_clr", 16'(o_ovf[0]), 16'h0);
        TC = 1'b1; Cen = 1'b1; Clr_ovf = 1'b1;
        cyc(1);
        TC = 1'b0; Cen = 1'b0; Clr_ovf = 1'b0;
        chk("ovf_setwins", 16'(o_ovf[0]), 16'h1);

        Din = 16'h0007;
        cyc(8);
        wait_an(4'b0111);
        chk("lz_d3", 16'(o_seg[0]), LZB ? 16'h00 : 16'h3F);
        wait_an(4'b1110);
        chk("lz_d0", 16'(o_seg[0]), 16'h07);
        Din = 16'h0000;
        cyc(8);
        wait_an(4'b1110);
        chk("zero_d0", 16'(o_seg[0]), 16'h3F);
        wait_an(4'b1101);
        chk("zero_d1", 16'(o_seg[0]), LZB ? 16'h00 : 16'h3F);

        wait_an(4'b1011);
        #3 MR = 1'b1;
        #1;
        chk("amr_an", 16'(o_an[0]), 16'hF);
        chk("amr_seg", 16'(o_seg[0]), 16'h00);
        chk("amr_ovf", 16'(o_ovf[0]), 16'h0);
        @(negedge clk);
        MR  = 1'b0;
        Din = 16'h5678;
        cyc(3);
        chk("mr_rel_an", 16'(o_an[0]), 16'hF);
        cyc(1);
        chk("mr_rel_first", 16'(o_an[0]), 16'hE);
        chk("mr_rel_seg", 16'(o_seg[0]), 16'h7F);

        for (int n = 0; n < 600; n++) begin
            Din     = 16'($urandom) >> (4 * ($urandom % 4));
            Hold    = ($urandom % 4) == 0;
            TC      = ($urandom % 8) == 0;
            Cen     = ($urandom % 2) == 1;
            Clr_ovf = ($urandom % 12) == 0;
            MR      = ($urandom % 150) == 0;
            cyc(1);
        end
        MR = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
